// File: rtl/data_cache_pkg.sv
// Shared encodings for the L1 data cache: CPU load/store function codes and FSM states.
package data_cache_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] ST_SB = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SW = 2'b10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

endpackage

// File: rtl/data_cache_align.sv
// Byte/halfword extraction with sign or zero extension for loads, and
// byte-lane merge of right-aligned store data into the addressed word.
module data_cache_align
    import data_cache_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  store_kind,
    input  logic [1:0]  byte_sel,
    input  logic [31:0] word_in,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = word_in[7:0];
        case (byte_sel)
            2'd0: sel_byte = word_in[7:0];
            2'd1: sel_byte = word_in[15:8];
            2'd2: sel_byte = word_in[23:16];
            2'd3: sel_byte = word_in[31:24];
        endcase
        sel_half = byte_sel[1] ? word_in[31:16] : word_in[15:0];
    end

    // Unused funct3 codes deliberately return zero rather than a raw word.
    always_comb begin
        load_data = '0;
        case (funct3)
            F3_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_LH:   load_data = {{16{sel_half[15]}}, sel_half};
            F3_LW:   load_data = word_in;
            F3_LBU:  load_data = {24'd0, sel_byte};
            F3_LHU:  load_data = {16'd0, sel_half};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        merged_word = word_in;
        case (store_kind)
            ST_SB: begin
                case (byte_sel)
                    2'd0: merged_word[7:0]   = store_data[7:0];
                    2'd1: merged_word[15:8]  = store_data[7:0];
                    2'd2: merged_word[23:16] = store_data[7:0];
                    2'd3: merged_word[31:24] = store_data[7:0];
                endcase
            end
            ST_SH: begin
                if (byte_sel[1])
                    merged_word[31:16] = store_data[15:0];
                else
                    merged_word[15:0] = store_data[15:0];
            end
            ST_SW:   merged_word = store_data;
            default: merged_word = word_in;
        endcase
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache sitting between the
// CPU MEM stage and a line-wide main memory with a busywait handshake.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int LINES          = 8,
    parameter int WORDS_PER_LINE = 4,
    localparam int INDEX_W = $clog2(LINES),
    localparam int OFFS_W  = $clog2(WORDS_PER_LINE) + 2,
    localparam int TAG_W   = 32 - INDEX_W - OFFS_W,
    localparam int LINE_W  = 32 * WORDS_PER_LINE
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [3:0]          READ,
    input  logic [2:0]          WRITE,
    input  logic [31:0]         ADDRESS,
    input  logic [31:0]         WRITEDATA,
    output logic [31:0]         READDATA,
    output logic                BUSYWAIT,
    output logic                MEM_READ,
    output logic                MEM_WRITE,
    output logic [31-OFFS_W:0]  MEM_ADDRESS,
    output logic [LINE_W-1:0]   MEM_WRITEDATA,
    input  logic [LINE_W-1:0]   MEM_READDATA,
    input  logic                MEM_BUSYWAIT
);

    localparam int WORD_W = OFFS_W - 2;

    state_t               state;
    logic [TAG_W-1:0]     fill_tag;
    logic [INDEX_W-1:0]   fill_index;
    logic                 mem_read_q;
    logic                 mem_write_q;
    logic [31-OFFS_W:0]   mem_address_q;

    logic [LINE_W-1:0]    data_array [LINES];
    logic [TAG_W-1:0]     tag_array  [LINES];
    logic [LINES-1:0]     valid;
    logic [LINES-1:0]     dirty;

    logic [TAG_W-1:0]     req_tag;
    logic [INDEX_W-1:0]   req_index;
    logic [WORD_W-1:0]    req_word;
    logic                 load_req;
    logic                 store_req;
    logic                 request;
    logic                 hit;
    logic [LINE_W-1:0]    cur_line;
    logic [31:0]          cur_word;
    logic [31:0]          align_load;
    logic [31:0]          merged_word;
    logic [LINE_W-1:0]    merged_line;
    logic                 store_hit_we;
    logic                 fill_we;

    assign req_tag   = ADDRESS[31 -: TAG_W];
    assign req_index = ADDRESS[OFFS_W +: INDEX_W];
    assign req_word  = ADDRESS[2 +: WORD_W];

    // A simultaneous load and store services only the load.
    assign load_req  = READ[3];
    assign store_req = WRITE[2] && !READ[3];
    assign request   = READ[3] || WRITE[2];

    assign hit      = valid[req_index] && (tag_array[req_index] == req_tag);
    assign cur_line = data_array[req_index];
    assign cur_word = cur_line[{req_word, 5'b0} +: 32];

    data_cache_align u_align (
        .funct3      (READ[2:0]),
        .store_kind  (WRITE[1:0]),
        .byte_sel    (ADDRESS[1:0]),
        .word_in     (cur_word),
        .store_data  (WRITEDATA),
        .load_data   (align_load),
        .merged_word (merged_word)
    );

    always_comb begin
        merged_line = cur_line;
        merged_line[{req_word, 5'b0} +: 32] = merged_word;
    end

    assign store_hit_we = !RESET && (state == IDLE) && store_req && hit;
    assign fill_we      = !RESET && (state == ALLOCATE) && !MEM_BUSYWAIT;

    assign BUSYWAIT      = (state != IDLE) || (request && !hit);
    assign READDATA      = ((state == IDLE) && load_req && hit) ? align_load : 32'd0;
    assign MEM_READ      = mem_read_q;
    assign MEM_WRITE     = mem_write_q;
    assign MEM_ADDRESS   = mem_address_q;
    assign MEM_WRITEDATA = data_array[fill_index];

    // Control FSM; memory strobes and line address are registered so they only
    // change on state transitions and can never overlap.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            valid       <= '0;
            dirty       <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (request && !hit) begin
                        fill_tag   <= req_tag;
                        fill_index <= req_index;
                        if (valid[req_index] && dirty[req_index]) begin
                            state         <= WRITEBACK;
                            mem_write_q   <= 1'b1;
                            mem_address_q <= {tag_array[req_index], req_index};
                        end else begin
                            state         <= ALLOCATE;
                            mem_read_q    <= 1'b1;
                            mem_address_q <= {req_tag, req_index};
                        end
                    end else if (store_req) begin
                        dirty[req_index] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (!MEM_BUSYWAIT) begin
                        state         <= ALLOCATE;
                        mem_write_q   <= 1'b0;
                        mem_read_q    <= 1'b1;
                        mem_address_q <= {fill_tag, fill_index};
                    end
                end
                ALLOCATE: begin
                    if (!MEM_BUSYWAIT) begin
                        state             <= IDLE;
                        mem_read_q        <= 1'b0;
                        valid[fill_index] <= 1'b1;
                        dirty[fill_index] <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data and tag storage are never cleared; valid bits alone gate their use.
    always_ff @(posedge CLK) begin
        if (fill_we) begin
            data_array[fill_index] <= MEM_READDATA;
            tag_array[fill_index]  <= fill_tag;
        end else if (store_hit_we) begin
            data_array[req_index] <= merged_line;
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: table of hit vectors plus hand-written
// miss, eviction, write-allocate and reset sequences against a line memory model.
module tb_data_cache;

    localparam int MEM_LAT = 3;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [3:0]    READ;
    logic [2:0]    WRITE;
    logic [31:0]   ADDRESS;
    logic [31:0]   WRITEDATA;
    logic [31:0]   READDATA;
    logic          BUSYWAIT;
    logic          MEM_READ;
    logic          MEM_WRITE;
    logic [27:0]   MEM_ADDRESS;
    logic [127:0]  MEM_WRITEDATA;
    logic [127:0]  MEM_READDATA;
    logic          MEM_BUSYWAIT;

    data_cache dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  rd;
        logic [2:0]  wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t          vecs[$];
    logic [31:0]   exp_q[$];
    string         name_q[$];
    logic [127:0]  mem_lines [int];

    int compared = 0;
    int mismatched = 0;
    int cycle = 0;
    int mem_cnt = 0;
    int fill_count = 0;
    int wb_count = 0;
    int write_cycles = 0;
    int overlap_count = 0;
    int wb_cycle = 0;
    int fill_cycle = 0;
    logic [27:0]  last_wb_addr = '0;
    logic [127:0] last_wb_data = '0;
    logic [27:0]  last_fill_addr = '0;

    function automatic logic [127:0] default_line(input logic [27:0] a);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = {a[23:0], 8'(w)};
        return l;
    endfunction

    function automatic logic [127:0] read_line(input logic [27:0] a);
        if (mem_lines.exists(int'(a))) return mem_lines[int'(a)];
        return default_line(a);
    endfunction

    always @(posedge CLK) cycle <= cycle + 1;

    // Line memory: busy for MEM_LAT cycles of a request, then one ready cycle.
    always @(negedge CLK) begin
        if (MEM_READ && MEM_WRITE) overlap_count++;
        if (MEM_WRITE) write_cycles++;
        if (MEM_READ || MEM_WRITE) begin
            if (mem_cnt == MEM_LAT) begin
                MEM_BUSYWAIT = 1'b0;
                mem_cnt = 0;
                if (MEM_WRITE) begin
                    mem_lines[int'(MEM_ADDRESS)] = MEM_WRITEDATA;
                    last_wb_addr = MEM_ADDRESS;
                    last_wb_data = MEM_WRITEDATA;
                    wb_cycle = cycle;
                    wb_count++;
                end else begin
                    MEM_READDATA = read_line(MEM_ADDRESS);
                    last_fill_addr = MEM_ADDRESS;
                    fill_cycle = cycle;
                    fill_count++;
                end
            end else begin
                MEM_BUSYWAIT = 1'b1;
                mem_cnt++;
            end
        end else begin
            MEM_BUSYWAIT = 1'b1;
            mem_cnt = 0;
        end
    end

    task automatic compareValue(input string name, input logic [127:0] actual, input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] exp, input string name,
                                 output int wait_cycles);
        @(negedge CLK);
        READ = rd;
        WRITE = wr;
        ADDRESS = addr;
        WRITEDATA = wdata;
        exp_q.push_back(exp);
        name_q.push_back(name);
        #1;
        wait_cycles = 0;
        while (BUSYWAIT !== 1'b0 && wait_cycles < 100) begin
            @(negedge CLK);
            #1;
            wait_cycles++;
        end
        if (BUSYWAIT !== 1'b0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s timeout: BUSYWAIT=%b after %0d cycles, want 0", name, BUSYWAIT, wait_cycles);
        end
    endtask

    task automatic checkOutput();
        logic [31:0] exp;
        string name;
        exp = exp_q.pop_front();
        name = name_q.pop_front();
        compareValue(name, READDATA, exp);
    endtask

    task automatic doAccess(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp, input int exp_wait,
                            input string name);
        int waited;
        applyStimulus(rd, wr, addr, wdata, exp, name, waited);
        checkOutput();
        compareValue({name, " stall"}, 128'(waited), 128'(exp_wait));
    endtask

    task automatic idleBus();
        @(negedge CLK);
        READ = 4'd0;
        WRITE = 3'd0;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int fills0, wbs0, wcyc0, k;
        RESET = 1'b1;
        READ = 4'd0;
        WRITE = 3'd0;
        ADDRESS = '0;
        WRITEDATA = '0;
        MEM_BUSYWAIT = 1'b1;
        MEM_READDATA = '0;
        mem_lines[28'h004] = {32'h4, 32'h3, 32'h2, 32'h1};
        mem_lines[28'h00C] = {32'hC3, 32'hC2, 32'hC1, 32'hC0};

        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        #1;
        compareValue("reset BUSYWAIT", BUSYWAIT, 1'b0);
        compareValue("reset MEM_READ", MEM_READ, 1'b0);
        compareValue("reset MEM_WRITE", MEM_WRITE, 1'b0);
        compareValue("reset READDATA", READDATA, 32'd0);

        // Cold load miss: request cycle + 3 busy + 1 ready before the hit cycle.
        fills0 = fill_count;
        doAccess(4'b1010, 3'b000, 32'h40, 32'h0, 32'h1, 5, "cold LW 0x40");
        compareValue("cold fill addr", last_fill_addr, 28'h004);
        compareValue("cold fill count", 128'(fill_count - fills0), 128'd1);
        compareValue("cold no writes", 128'(write_cycles), 128'd0);

        vecs.push_back('{4'b0000, 3'b110, 32'h40, 32'h8081F0FF, 32'h0,        "SW word0"});
        vecs.push_back('{4'b1000, 3'b000, 32'h40, 32'h0,        32'hFFFFFFFF, "LB 0x40"});
        vecs.push_back('{4'b1100, 3'b000, 32'h40, 32'h0,        32'h000000FF, "LBU 0x40"});
        vecs.push_back('{4'b1001, 3'b000, 32'h42, 32'h0,        32'hFFFF8081, "LH 0x42"});
        vecs.push_back('{4'b1101, 3'b000, 32'h42, 32'h0,        32'h00008081, "LHU 0x42"});
        vecs.push_back('{4'b1001, 3'b000, 32'h43, 32'h0,        32'hFFFF8081, "LH 0x43 a0 ignored"});
        vecs.push_back('{4'b1000, 3'b000, 32'h43, 32'h0,        32'hFFFFFF80, "LB 0x43"});
        vecs.push_back('{4'b1101, 3'b000, 32'h40, 32'h0,        32'h0000F0FF, "LHU 0x40"});
        vecs.push_back('{4'b1010, 3'b000, 32'h43, 32'h0,        32'h8081F0FF, "LW 0x43 low bits ignored"});
        vecs.push_back('{4'b1011, 3'b000, 32'h40, 32'h0,        32'h0,        "unused funct3"});
        vecs.push_back('{4'b0000, 3'b100, 32'h41, 32'h000000AA, 32'h0,        "SB 0x41"});
        vecs.push_back('{4'b1010, 3'b000, 32'h40, 32'h0,        32'h8081AAFF, "LW after SB"});
        vecs.push_back('{4'b0000, 3'b101, 32'h46, 32'hFFFF1234, 32'h0,        "SH 0x46"});
        vecs.push_back('{4'b1010, 3'b000, 32'h44, 32'h0,        32'h12340002, "LW after SH"});
        vecs.push_back('{4'b1010, 3'b110, 32'h48, 32'h0000FFFF, 32'h3,        "load wins over store"});
        vecs.push_back('{4'b1010, 3'b000, 32'h48, 32'h0,        32'h3,        "ignored store"});
        vecs.push_back('{4'b0000, 3'b100, 32'h4F, 32'h00000077, 32'h0,        "SB 0x4F"});
        vecs.push_back('{4'b1010, 3'b000, 32'h4C, 32'h0,        32'h77000004, "LW after SB lane3"});

        for (int i = 0; i < vecs.size(); i++) begin
            fills0 = fill_count;
            wcyc0 = write_cycles;
            doAccess(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp, 0, vecs[i].name);
            compareValue({vecs[i].name, " no traffic"}, 128'((fill_count - fills0) + (write_cycles - wcyc0)), 128'd0);
        end

        // Dirty eviction: writeback of the merged line precedes the fill.
        fills0 = fill_count;
        wbs0 = wb_count;
        doAccess(4'b1010, 3'b000, 32'hC0, 32'h0, 32'hC0, 9, "evict LW 0xC0");
        compareValue("evict wb addr", last_wb_addr, 28'h004);
        compareValue("evict wb data", last_wb_data, {32'h77000004, 32'h3, 32'h12340002, 32'h8081AAFF});
        compareValue("evict fill addr", last_fill_addr, 28'h00C);
        compareValue("evict wb before fill", 128'(wb_cycle < fill_cycle), 128'd1);
        compareValue("evict counts", 128'((wb_count - wbs0) * 16 + (fill_count - fills0)), 128'h11);

        wbs0 = wb_count;
        doAccess(4'b1010, 3'b000, 32'h40, 32'h0, 32'h8081AAFF, 5, "refetch LW 0x40");
        compareValue("refetch clean victim", 128'(wb_count - wbs0), 128'd0);

        // Store miss: fill first, then merge as a store hit.
        fills0 = fill_count;
        doAccess(4'b0000, 3'b110, 32'h100, 32'hDEADBEEF, 32'h0, 5, "SW miss 0x100");
        compareValue("SW miss fill count", 128'(fill_count - fills0), 128'd1);
        compareValue("SW miss fill addr", last_fill_addr, 28'h010);
        doAccess(4'b1010, 3'b000, 32'h100, 32'h0, 32'hDEADBEEF, 0, "LW 0x100 after SW");
        doAccess(4'b1010, 3'b000, 32'h104, 32'h0, default_line(28'h010)[63:32], 0, "LW 0x104 filled");

        // Reset while a fill is outstanding.
        @(negedge CLK);
        READ = 4'b1010;
        WRITE = 3'b000;
        ADDRESS = 32'h2A0;
        fills0 = fill_count;
        k = 0;
        #1;
        while (MEM_READ !== 1'b1 && k < 20) begin
            @(negedge CLK);
            #1;
            k++;
        end
        compareValue("reset-test fill started", MEM_READ, 1'b1);
        RESET = 1'b1;
        READ = 4'd0;
        @(negedge CLK);
        #1;
        RESET = 1'b0;
        compareValue("abandon MEM_READ", MEM_READ, 1'b0);
        compareValue("abandon BUSYWAIT", BUSYWAIT, 1'b0);
        compareValue("abandon no fill", 128'(fill_count - fills0), 128'd0);
        doAccess(4'b1010, 3'b000, 32'h2A0, 32'h0, default_line(28'h02A)[31:0], 5, "LW 0x2A0 misses again");

        wbs0 = wb_count;
        doAccess(4'b1010, 3'b000, 32'h100, 32'h0, default_line(28'h010)[31:0], 5, "LW 0x100 dirty lost");
        doAccess(4'b1010, 3'b000, 32'h40, 32'h0, 32'h8081AAFF, 5, "LW 0x40 cold after reset");
        compareValue("post-reset no writeback", 128'(wb_count - wbs0), 128'd0);

        idleBus();
        #1;
        compareValue("idle READDATA", READDATA, 32'd0);
        compareValue("read/write overlap", 128'(overlap_count), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
